// File: rtl/cmprs_status_pkg.sv
// Shared definitions for the compressor status decoder: FSM state encoding,
// status word bit positions and interrupt bit positions.
package cmprs_status_pkg;

   // Frame lifecycle as seen from the status word.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   // Bit positions inside the 3-bit status word.
   localparam int STS_FLUSH = 2;  // flushing_fifo
   localparam int STS_STUFF = 1;  // stuffer_running
   localparam int STS_READ  = 0;  // reading_frame

   // Bit positions inside irq_en / irq_clr.
   localparam int IRQ_DONE = 0;
   localparam int IRQ_ERR  = 1;

endpackage

// File: rtl/cmprs_status_decoder_if.sv
// Bus bundle between the compressor status source / register block and the
// status decoder. There is no valid/ready handshake here: status is a level
// sampled every mclk, while irq_en_wr and irq_clr are single-cycle strobes
// that act on the next rising edge. fsm_state exposes the decoder FSM.
interface cmprs_status_decoder_if #(
   parameter int CNTR_BITS = 16,
   parameter int TS_BITS   = 32
);
   import cmprs_status_pkg::*;

   logic [2:0]           status;
   logic                 irq_en_wr;
   logic [1:0]           irq_en_data;
   logic [1:0]           irq_clr;
   logic                 frame_done;
   logic                 frame_abort;
   logic [CNTR_BITS-1:0] done_cnt;
   logic                 busy;
   logic                 done_pend;
   logic                 err_pend;
   logic                 irq;
   logic [TS_BITS-1:0]   last_done_ts;
   state_t               fsm_state;

   modport master (
      output status, irq_en_wr, irq_en_data, irq_clr,
      input  frame_done, frame_abort, done_cnt, busy, done_pend, err_pend,
             irq, last_done_ts, fsm_state
   );

   modport slave (
      input  status, irq_en_wr, irq_en_data, irq_clr,
      output frame_done, frame_abort, done_cnt, busy, done_pend, err_pend,
             irq, last_done_ts, fsm_state
   );

endinterface

// File: rtl/cmprs_sticky_bit.sv
// Sticky flag: set wins over clear when both arrive in the same cycle, so an
// event coinciding with software acknowledging the previous one is not lost.
module cmprs_sticky_bit (
   input  logic mclk,
   input  logic mrst,
   input  logic set,
   input  logic clr,
   output logic q
);

   // Flag register with set priority.
   always_ff @(posedge mclk) begin
      if (mrst)     q <= 1'b0;
      else if (set) q <= 1'b1;
      else if (clr) q <= 1'b0;
   end

endmodule

// File: rtl/cmprs_status_decoder.sv
// Receive-side decoder of the compressor status word
// {flushing_fifo, stuffer_running, reading_frame}. Tracks each frame through
// IDLE/ACTIVE/FLUSH, pulses frame_done per completed frame (frame_abort when
// activity stops without a flush), counts completed frames, flags flushes
// that run too long and raises a maskable registered interrupt.
// Optional build macro CMPRS_STATUS_TIMESTAMP_EN adds a free-running
// timestamp captured into last_done_ts on every frame_done; without it
// last_done_ts is constant zero.
module cmprs_status_decoder
   import cmprs_status_pkg::*;
#(
   parameter int CNTR_BITS     = 16,
   parameter int FLUSH_TIMEOUT = 4096,
   parameter int TS_BITS       = 32
) (
   input  logic mclk,
   input  logic mrst,
   cmprs_status_decoder_if.slave bus
);

   // Counter saturates one past the trigger value so the trigger compare is
   // true for exactly one cycle per FLUSH visit.
   localparam int                TO_BITS = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(FLUSH_TIMEOUT - 1);
   localparam logic [TO_BITS-1:0] TO_SAT  = TO_BITS'(FLUSH_TIMEOUT);

   logic [2:0]           status_r;
   logic                 flush_d;
   logic                 flush_rise;
   logic                 flush_fall;
   logic                 activity;
   state_t               state;
   state_t               state_nxt;
   logic                 flush_end;
   logic                 abort;
   logic                 busy_r;
   logic                 frame_done_r;
   logic                 frame_abort_r;
   logic [CNTR_BITS-1:0] done_cnt_r;
   logic [TO_BITS-1:0]   to_cnt;
   logic                 to_hit;
   logic [1:0]           irq_en;
   logic                 irq_r;
   logic                 done_pend;
   logic                 err_pend;

   // Input stage: one register on status plus the previous flush bit for
   // edge detection; everything downstream works on these.
   always_ff @(posedge mclk) begin
      if (mrst) begin
         status_r <= 3'b000;
         flush_d  <= 1'b0;
      end else begin
         status_r <= bus.status;
         flush_d  <= status_r[STS_FLUSH];
      end
   end

   assign flush_rise = status_r[STS_FLUSH] & ~flush_d;
   assign flush_fall = ~status_r[STS_FLUSH] & flush_d;
   assign activity   = status_r[STS_STUFF] | status_r[STS_READ];

   // State register; pulses and busy are registered from the next state so
   // they line up with the state they describe.
   always_ff @(posedge mclk) begin
      if (mrst) begin
         state         <= ST_IDLE;
         busy_r        <= 1'b0;
         frame_done_r  <= 1'b0;
         frame_abort_r <= 1'b0;
      end else begin
         state         <= state_nxt;
         busy_r        <= (state_nxt != ST_IDLE);
         frame_done_r  <= flush_end;
         frame_abort_r <= abort;
      end
   end

   // Next-state decode. A flush seen from IDLE (e.g. already running at reset
   // release) goes straight to FLUSH; a flush ending with activity already
   // present continues into the next frame without passing through IDLE.
   always_comb begin
      state_nxt = state;
      flush_end = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (status_r[STS_FLUSH]) state_nxt = ST_FLUSH;
            else if (activity)       state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (flush_rise) begin
               state_nxt = ST_FLUSH;
            end else if (status_r == 3'b000) begin
               state_nxt = ST_IDLE;
               abort     = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (flush_fall) begin
               flush_end = 1'b1;
               state_nxt = activity ? ST_ACTIVE : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Completed-frame counter, wraps naturally at 2^CNTR_BITS.
   always_ff @(posedge mclk) begin
      if (mrst)           done_cnt_r <= '0;
      else if (flush_end) done_cnt_r <= done_cnt_r + CNTR_BITS'(1);
   end

   // Flush timeout counter: held at zero outside FLUSH, so it starts from
   // zero on every FLUSH entry, then counts up and saturates.
   always_ff @(posedge mclk) begin
      if (mrst)                   to_cnt <= '0;
      else if (state != ST_FLUSH) to_cnt <= '0;
      else if (to_cnt != TO_SAT)  to_cnt <= to_cnt + TO_BITS'(1);
   end

   assign to_hit = (state == ST_FLUSH) && (to_cnt == TO_LAST);

   cmprs_sticky_bit u_done_pend (
      .mclk (mclk),
      .mrst (mrst),
      .set  (flush_end),
      .clr  (bus.irq_clr[IRQ_DONE]),
      .q    (done_pend)
   );

   cmprs_sticky_bit u_err_pend (
      .mclk (mclk),
      .mrst (mrst),
      .set  (to_hit),
      .clr  (bus.irq_clr[IRQ_ERR]),
      .q    (err_pend)
   );

   // Interrupt enable register and registered interrupt request.
   always_ff @(posedge mclk) begin
      if (mrst) begin
         irq_en <= 2'b00;
         irq_r  <= 1'b0;
      end else begin
         if (bus.irq_en_wr) irq_en <= bus.irq_en_data;
         irq_r <= (done_pend & irq_en[IRQ_DONE]) | (err_pend & irq_en[IRQ_ERR]);
      end
   end

`ifdef CMPRS_STATUS_TIMESTAMP_EN
   logic [TS_BITS-1:0] ts_cnt;
   logic [TS_BITS-1:0] last_ts;

   // Free-running timestamp, captured on the edge that raises frame_done.
   always_ff @(posedge mclk) begin
      if (mrst) begin
         ts_cnt  <= '0;
         last_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_BITS'(1);
         if (flush_end) last_ts <= ts_cnt;
      end
   end

   assign bus.last_done_ts = last_ts;
`else
   assign bus.last_done_ts = {TS_BITS{1'b0}};
`endif

   assign bus.frame_done  = frame_done_r;
   assign bus.frame_abort = frame_abort_r;
   assign bus.done_cnt    = done_cnt_r;
   assign bus.busy        = busy_r;
   assign bus.done_pend   = done_pend;
   assign bus.err_pend    = err_pend;
   assign bus.irq         = irq_r;
   assign bus.fsm_state   = state;

endmodule

// File: tb/tb_cmprs_status_decoder.sv
// Directed bench for cmprs_status_decoder: a table of status steps with
// hand-computed expected outputs, plus hand-written sequences for exact
// latency, flush timeout, counter wrap with set/clear priority and reset in
// the middle of a flush. Every frame_done is checked against an expected
// done_cnt queue.
module tb_cmprs_status_decoder;
   import cmprs_status_pkg::*;

   localparam int CB  = 4;
   localparam int TO  = 8;
   localparam int TSB = 32;
   localparam int NV  = 15;

   // ---------------- clock / reset ----------------
   logic mclk = 1'b0;
   logic mrst = 1'b1;
   always #5 mclk = ~mclk;

   cmprs_status_decoder_if #(.CNTR_BITS(CB), .TS_BITS(TSB)) bus ();

   cmprs_status_decoder #(
      .CNTR_BITS     (CB),
      .FLUSH_TIMEOUT (TO),
      .TS_BITS       (TSB)
   ) dut (
      .mclk (mclk),
      .mrst (mrst),
      .bus  (bus)
   );

   // ---------------- scoreboard state ----------------
   int checks  = 0;
   int errors  = 0;
   int fd_seen = 0;
   int ab_seen = 0;
   logic [CB-1:0] exp_q[$];
   logic [CB-1:0] exp_cnt = '0;

   typedef struct {
      logic [2:0]    status;
      int            cyc;
      logic          en_wr;
      logic [1:0]    en_data;
      logic [1:0]    clr;
      int            fd;
      int            ab;
      logic          busy;
      logic          dp;
      logic          ep;
      logic          irq;
      logic [CB-1:0] cnt;
   } vec_t;

   vec_t tbl [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_frame();
      exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back(exp_cnt);
   endtask

   // One clock: sample outputs 1ns after the edge, drop strobes, score pulses.
   task automatic tick();
      @(posedge mclk);
      #1;
      bus.irq_en_wr = 1'b0;
      bus.irq_clr   = 2'b00;
      if (bus.frame_done === 1'b1) begin
         fd_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got pulse with done_cnt=%0d, expected no pulse", bus.done_cnt);
         end else begin
            check("sb_done_cnt", 32'(bus.done_cnt), 32'(exp_q.pop_front()));
         end
      end
      if (bus.frame_abort === 1'b1) ab_seen++;
   endtask

   // ---------------- driver ----------------
   task automatic run_row(input int i);
      int fd0;
      int ab0;
      vec_t v;
      v   = tbl[i];
      fd0 = fd_seen;
      ab0 = ab_seen;
      bus.status      = v.status;
      bus.irq_en_wr   = v.en_wr;
      bus.irq_en_data = v.en_data;
      bus.irq_clr     = v.clr;
      for (int k = 0; k < v.fd; k++) expect_frame();
      repeat (v.cyc) tick();
      check($sformatf("r%0d_fd_pulses", i), 32'(fd_seen - fd0), 32'(v.fd));
      check($sformatf("r%0d_ab_pulses", i), 32'(ab_seen - ab0), 32'(v.ab));
      check($sformatf("r%0d_busy", i),      32'(bus.busy),      32'(v.busy));
      check($sformatf("r%0d_done_pend", i), 32'(bus.done_pend), 32'(v.dp));
      check($sformatf("r%0d_err_pend", i),  32'(bus.err_pend),  32'(v.ep));
      check($sformatf("r%0d_irq", i),       32'(bus.irq),       32'(v.irq));
      check($sformatf("r%0d_done_cnt", i),  32'(bus.done_cnt),  32'(v.cnt));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_frame_done"},  32'(bus.frame_done),  32'd0);
      check({tag, "_frame_abort"}, 32'(bus.frame_abort), 32'd0);
      check({tag, "_done_cnt"},    32'(bus.done_cnt),    32'd0);
      check({tag, "_busy"},        32'(bus.busy),        32'd0);
      check({tag, "_done_pend"},   32'(bus.done_pend),   32'd0);
      check({tag, "_err_pend"},    32'(bus.err_pend),    32'd0);
      check({tag, "_irq"},         32'(bus.irq),         32'd0);
      check({tag, "_last_ts"},     32'(bus.last_done_ts), 32'd0);
      check({tag, "_state"},       32'(bus.fsm_state),   32'(ST_IDLE));
   endtask

   task automatic simple_frame();
      bus.status = 3'b001;
      repeat (3) tick();
      bus.status = 3'b100;
      repeat (3) tick();
      bus.status = 3'b000;
      expect_frame();
      repeat (3) tick();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected test to finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int fd0;
      int ab0;

      //        status  cyc en  data   clr    fd ab busy dp ep irq cnt
      tbl[0]  = '{3'b001, 10, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'd0};
      tbl[1]  = '{3'b011, 10, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'd0};
      tbl[2]  = '{3'b110,  4, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'd0};
      tbl[3]  = '{3'b000,  2, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 4'd1};
      tbl[4]  = '{3'b001,  3, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'd1};
      tbl[5]  = '{3'b110,  4, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4'd1};
      tbl[6]  = '{3'b001,  5, 0, 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 4'd2};
      tbl[7]  = '{3'b110,  4, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 4'd2};
      tbl[8]  = '{3'b000,  5, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 4'd3};
      tbl[9]  = '{3'b001,  5, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 4'd3};
      tbl[10] = '{3'b000,  5, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 4'd3};
      tbl[11] = '{3'b000,  3, 1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 4'd3};
      tbl[12] = '{3'b000,  3, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 4'd3};
      tbl[13] = '{3'b000,  2, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 4'd3};
      tbl[14] = '{3'b000,  4, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 4'd4};

      bus.status      = 3'b000;
      bus.irq_en_wr   = 1'b0;
      bus.irq_en_data = 2'b00;
      bus.irq_clr     = 2'b00;

      // Reset state.
      mrst = 1'b1;
      repeat (3) tick();
      mrst = 1'b0;
      check_all_zero("reset");

      // First frame build-up: 001 -> 011 -> 110.
      for (int i = 0; i <= 2; i++) run_row(i);

      // Exact frame_done latency after 110 -> 000.
      bus.status = 3'b000;
      expect_frame();
      tick();
      check("lat_e0_frame_done", 32'(bus.frame_done), 32'd0);
      check("lat_e0_busy",       32'(bus.busy),       32'd1);
      tick();
      check("lat_e1_frame_done", 32'(bus.frame_done), 32'd1);
      check("lat_e1_busy",       32'(bus.busy),       32'd0);
      check("lat_e1_done_cnt",   32'(bus.done_cnt),   32'd1);
      check("lat_e1_done_pend",  32'(bus.done_pend),  32'd1);
      check("lat_e1_irq",        32'(bus.irq),        32'd0);
      tick();
      check("lat_e2_frame_done", 32'(bus.frame_done), 32'd0);

      // Clear, back-to-back frames, abort, done interrupt.
      for (int i = 3; i <= 13; i++) run_row(i);

      // Flush timeout: status 100 from IDLE, err enable already set.
      bus.status = 3'b100;
      repeat (9) tick();
      check("to_t9_err_pend",  32'(bus.err_pend), 32'd0);
      check("to_t9_busy",      32'(bus.busy),     32'd1);
      tick();
      check("to_t10_err_pend", 32'(bus.err_pend), 32'd1);
      check("to_t10_irq",      32'(bus.irq),      32'd0);
      tick();
      check("to_t11_irq",      32'(bus.irq),      32'd1);
      repeat (5) tick();
      check("to_hold_state",   32'(bus.fsm_state), 32'(ST_FLUSH));
      bus.irq_clr = 2'b10;
      tick();
      check("to_clr_err_pend", 32'(bus.err_pend), 32'd0);
      tick();
      check("to_clr_irq",      32'(bus.irq),      32'd0);
      repeat (3) tick();
      check("to_once_err_pend", 32'(bus.err_pend), 32'd0);
      run_row(14);

      // Counter wrap: 11 frames to reach 15, then one more with irq_clr[0]
      // arriving on the frame_done edge.
      for (int f = 0; f < 11; f++) simple_frame();
      check("wrap_cnt_15", 32'(bus.done_cnt), 32'd15);
      bus.status = 3'b001;
      repeat (3) tick();
      bus.status = 3'b100;
      repeat (3) tick();
      bus.status = 3'b000;
      expect_frame();
      tick();
      bus.irq_clr = 2'b01;
      tick();
      check("prio_frame_done", 32'(bus.frame_done), 32'd1);
      check("prio_done_pend",  32'(bus.done_pend),  32'd1);
      check("wrap_cnt_0",      32'(bus.done_cnt),   32'd0);
      tick();
      check("prio_done_pend_hold", 32'(bus.done_pend), 32'd1);

      // Reset in the middle of a flush with the interrupt asserted.
      bus.irq_en_wr   = 1'b1;
      bus.irq_en_data = 2'b11;
      tick();
      tick();
      check("pre_rst_irq", 32'(bus.irq), 32'd1);
      bus.status = 3'b100;
      repeat (3) tick();
      check("pre_rst_state", 32'(bus.fsm_state), 32'(ST_FLUSH));
      fd0  = fd_seen;
      ab0  = ab_seen;
      mrst = 1'b1;
      tick();
      mrst = 1'b0;
      exp_cnt = '0;
      check_all_zero("midrst");
      tick();
      check("rel_e0_busy",  32'(bus.busy), 32'd0);
      tick();
      check("rel_e1_busy",  32'(bus.busy), 32'd1);
      check("rel_e1_state", 32'(bus.fsm_state), 32'(ST_FLUSH));
      check("rst_no_fd",    32'(fd_seen - fd0), 32'd0);
      check("rst_no_ab",    32'(ab_seen - ab0), 32'd0);
      bus.status = 3'b000;
      expect_frame();
      repeat (3) tick();
      check("rel_done_cnt",  32'(bus.done_cnt),  32'd1);
      check("rel_done_pend", 32'(bus.done_pend), 32'd1);
      check("rel_irq",       32'(bus.irq),       32'd0);
      check("rel_busy",      32'(bus.busy),      32'd0);
`ifdef CMPRS_STATUS_TIMESTAMP_EN
      check("rel_last_ts",   32'(bus.last_done_ts), 32'd3);
`else
      check("rel_last_ts",   32'(bus.last_done_ts), 32'd0);
`endif

      check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
